// File: rtl/mm_mem_access_ctrl_pkg.sv
// Shared types for the MM-stage data-memory access controller.
package mm_mem_access_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mm_state_t;

    localparam int REG_ADDR_W = 5;

endpackage

// File: rtl/mm_mem_access_ctrl_if.sv
// Data-memory valid/ready request and response-pulse port.
interface mm_mem_access_ctrl_if #(
    parameter int DATA_WIDTH = 32
);

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_we;
    logic [DATA_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid,
        output mem_req_we,
        output mem_req_addr,
        output mem_req_wdata,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_we,
        input  mem_req_addr,
        input  mem_req_wdata,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_rdata
    );

endinterface

// File: rtl/mm_mem_access_ctrl.sv
// MM-stage controller: turns the EX/MM load/store into one memory transaction,
// stalls the pipeline until it completes, and reports load data or errors.
module mm_mem_access_ctrl
    import mm_mem_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  reg_write_in,
    input  logic [DATA_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  stall_out,
    mm_mem_access_ctrl_if.master  mem,
    output logic                  load_valid_out,
    output logic [DATA_WIDTH-1:0] load_data_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  err_out
);

    mm_state_t             r_state;
    mm_state_t             w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_reg_write;

    logic w_access;
    logic w_aligned;
    logic w_start;
    logic w_illegal;
    logic w_busy;
    logic w_handshake;
    logic w_rsp;
    logic w_timeout;

    assign w_access    = mem_read_in ^ mem_write_in;
    assign w_aligned   = (addr_in[1:0] == 2'b00);
    assign w_start     = (r_state == IDLE) && w_access && w_aligned;
    assign w_illegal   = (r_state == IDLE) &&
                         ((mem_read_in && mem_write_in) || (w_access && !w_aligned));
    assign w_busy      = (r_state == REQ) || (r_state == WAIT);
    assign w_handshake = (r_state == REQ) && mem.mem_req_valid && mem.mem_req_ready;
    assign w_rsp       = (r_state == WAIT) && mem.mem_rsp_valid;
    // Last busy cycle: the counter would reach TIMEOUT_CYCLES at this edge.
    assign w_timeout   = w_busy && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_next = REQ;
            REQ: begin
                if (w_timeout) begin
                    w_next = DONE;
                end else if (w_handshake) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (w_rsp || w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        stall_out = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE:    stall_out = w_start;
                REQ:     stall_out = 1'b1;
                WAIT:    stall_out = 1'b1;
                default: stall_out = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.mem_req_valid <= 1'b0;
            mem.mem_req_we    <= 1'b0;
            mem.mem_req_addr  <= '0;
            mem.mem_req_wdata <= '0;
            r_rd              <= '0;
            r_reg_write       <= 1'b0;
        end else if (w_start) begin
            mem.mem_req_valid <= 1'b1;
            mem.mem_req_we    <= mem_write_in;
            mem.mem_req_addr  <= addr_in;
            mem.mem_req_wdata <= wdata_in;
            r_rd              <= rd_in;
            r_reg_write       <= reg_write_in;
        end else if (w_handshake || (r_state == REQ && w_timeout)) begin
            mem.mem_req_valid <= 1'b0;
        end
    end

    // A response in the timeout cycle still counts as a normal completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_valid_out <= 1'b0;
            load_data_out  <= '0;
            rd_out         <= '0;
            err_out        <= 1'b0;
        end else begin
            load_valid_out <= 1'b0;
            err_out        <= w_illegal;
            if (w_rsp) begin
                if (!mem.mem_req_we && r_reg_write) begin
                    load_valid_out <= 1'b1;
                    load_data_out  <= mem.mem_rsp_rdata;
                    rd_out         <= r_rd;
                end
            end else if (w_timeout) begin
                err_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mm_mem_access_ctrl.sv
// Self-checking bench: reactive memory model plus transaction-level expectations.
module tb_mm_mem_access_ctrl;

    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read_in, mem_write_in, reg_write_in;
    logic [DW-1:0] addr_in, wdata_in;
    logic [4:0]    rd_in;
    logic          stall_out, load_valid_out, err_out;
    logic [DW-1:0] load_data_out;
    logic [4:0]    rd_out;

    mm_mem_access_ctrl_if #(.DATA_WIDTH(DW)) mem_if();

    mm_mem_access_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .reg_write_in   (reg_write_in),
        .addr_in        (addr_in),
        .wdata_in       (wdata_in),
        .rd_in          (rd_in),
        .stall_out      (stall_out),
        .mem            (mem_if.master),
        .load_valid_out (load_valid_out),
        .load_data_out  (load_data_out),
        .rd_out         (rd_out),
        .err_out        (err_out)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_last_data = '0;
    logic [4:0]    exp_last_rd   = '0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        mem_read_in            = 1'b0;
        mem_write_in           = 1'b0;
        reg_write_in           = 1'($urandom);
        addr_in                = $urandom;
        wdata_in               = $urandom;
        rd_in                  = 5'($urandom);
        mem_if.mem_req_ready   = 1'($urandom);
        mem_if.mem_rsp_valid   = 1'b0;
        mem_if.mem_rsp_rdata   = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        mem_read_in = 1'b1;
        addr_in     = 32'h100;
        @(posedge clk);
        #2;
        chk("reset stall_out", 32'(stall_out), 32'd0);
        chk("reset mem_req_valid", 32'(mem_if.mem_req_valid), 32'd0);
        chk("reset mem_req_we", 32'(mem_if.mem_req_we), 32'd0);
        chk("reset mem_req_addr", mem_if.mem_req_addr, 32'd0);
        chk("reset mem_req_wdata", mem_if.mem_req_wdata, 32'd0);
        chk("reset load_valid_out", 32'(load_valid_out), 32'd0);
        chk("reset load_data_out", load_data_out, 32'd0);
        chk("reset rd_out", 32'(rd_out), 32'd0);
        chk("reset err_out", 32'(err_out), 32'd0);
        drive_idle();
        next_cycle();
        rst = 1'b0;
    endtask

    // r: REQ cycles with ready low before acceptance; d: WAIT cycles before response.
    task automatic run_access(input bit is_load, input logic [DW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [4:0] rd,
                              input bit rw, input int r, input int d,
                              input logic [DW-1:0] rdata, input string name);
        int  n         = r + d + 2;
        bit  timed_out = (n > TO);
        int  exp_stall = 1 + (timed_out ? TO : n);
        int  exp_valid = (r + 1 < TO) ? r + 1 : TO;
        bit  exp_lv    = is_load && rw && !timed_out;
        int  stall_cnt = 1;
        int  vcnt      = 0;
        int  wcnt      = 0;
        bit  hs        = 0;
        bit  bad       = 0;
        bit  early     = 0;
        bit  done      = 0;

        next_cycle();
        chk({name, " entry err_out"}, 32'(err_out), 32'd0);
        chk({name, " entry load_valid_out"}, 32'(load_valid_out), 32'd0);
        chk({name, " retained load_data_out"}, load_data_out, exp_last_data);
        chk({name, " retained rd_out"}, 32'(rd_out), 32'(exp_last_rd));
        mem_read_in          = is_load;
        mem_write_in         = !is_load;
        reg_write_in         = rw;
        addr_in              = addr;
        wdata_in             = wdata;
        rd_in                = rd;
        mem_if.mem_req_ready = 1'($urandom);
        mem_if.mem_rsp_valid = 1'($urandom);
        mem_if.mem_rsp_rdata = $urandom;
        #1;
        chk({name, " first-cycle stall_out"}, 32'(stall_out), 32'd1);

        for (int k = 0; k < 200 && !done; k++) begin
            next_cycle();
            mem_if.mem_rsp_rdata = $urandom;
            if (mem_if.mem_req_valid) begin
                vcnt++;
                if (mem_if.mem_req_addr !== addr || mem_if.mem_req_wdata !== wdata ||
                    mem_if.mem_req_we !== !is_load) bad = 1;
                mem_if.mem_req_ready = (vcnt == r + 1);
                if (vcnt == r + 1) hs = 1;
                mem_if.mem_rsp_valid = 1'($urandom);
            end else begin
                mem_if.mem_req_ready = 1'($urandom);
                if (hs) begin
                    wcnt++;
                    mem_if.mem_rsp_valid = (wcnt == d + 1);
                    if (wcnt == d + 1) mem_if.mem_rsp_rdata = rdata;
                end else begin
                    mem_if.mem_rsp_valid = 1'($urandom);
                end
            end
            #1;
            if (stall_out) begin
                stall_cnt++;
                if (err_out || load_valid_out) early = 1;
            end else begin
                done = 1;
                chk({name, " done err_out"}, 32'(err_out), 32'(timed_out));
                chk({name, " done load_valid_out"}, 32'(load_valid_out), 32'(exp_lv));
                chk({name, " done mem_req_valid"}, 32'(mem_if.mem_req_valid), 32'd0);
                if (exp_lv) begin
                    chk({name, " load_data_out"}, load_data_out, rdata);
                    chk({name, " rd_out"}, 32'(rd_out), 32'(rd));
                end
            end
        end
        chk({name, " completed within bound"}, 32'(done), 32'd1);
        chk({name, " stall cycles"}, 32'(stall_cnt), 32'(exp_stall));
        chk({name, " mem_req_valid cycles"}, 32'(vcnt), 32'(exp_valid));
        chk({name, " request fields stable"}, 32'(bad), 32'd0);
        chk({name, " no early pulse"}, 32'(early), 32'd0);
        if (exp_lv) begin
            exp_last_data = rdata;
            exp_last_rd   = rd;
        end
    endtask

    task automatic test_illegal(input bit both, input string name);
        logic [DW-1:0] a = $urandom;
        bit            ld = 1'($urandom);
        next_cycle();
        chk({name, " entry err_out"}, 32'(err_out), 32'd0);
        drive_idle();
        if (both) begin
            a[1:0]       = 2'b00;
            mem_read_in  = 1'b1;
            mem_write_in = 1'b1;
        end else begin
            if (a[1:0] == 2'b00) a[1:0] = 2'b10;
            mem_read_in  = ld;
            mem_write_in = !ld;
        end
        addr_in = a;
        #1;
        chk({name, " stall_out"}, 32'(stall_out), 32'd0);
        chk({name, " no request"}, 32'(mem_if.mem_req_valid), 32'd0);
        next_cycle();
        drive_idle();
        chk({name, " err_out pulse"}, 32'(err_out), 32'd1);
        chk({name, " still no request"}, 32'(mem_if.mem_req_valid), 32'd0);
        chk({name, " no load_valid_out"}, 32'(load_valid_out), 32'd0);
        #1;
        chk({name, " stays idle"}, 32'(stall_out), 32'd0);
    endtask

    task automatic test_load();
        run_access(1, 32'h100, $urandom, 5'd7, 1, 0, 1, 32'hDEADBEEF, "load");
    endtask

    task automatic test_store();
        run_access(0, 32'h44, 32'h12345678, 5'd3, 1, 3, 0, $urandom, "store");
    endtask

    task automatic test_timeout();
        run_access(1, 32'h80, $urandom, 5'd9, 1, 0, 40, $urandom, "wait timeout");
        run_access(1, 32'h84, $urandom, 5'd10, 1, 12, 0, $urandom, "req timeout");
        run_access(0, 32'h88, $urandom, 5'd11, 1, 7, 0, $urandom, "ready at timeout");
    endtask

    task automatic test_resp_at_timeout();
        run_access(1, 32'h90, $urandom, 5'd12, 1, 0, TO - 2, $urandom, "rsp at timeout load");
        run_access(0, 32'h94, $urandom, 5'd13, 1, 3, TO - 5, $urandom, "rsp at timeout store");
    endtask

    task automatic test_back_to_back();
        run_access(1, 32'hA0, $urandom, 5'd1, 1, 0, 0, $urandom, "b2b 0");
        run_access(1, 32'hA4, $urandom, 5'd2, 0, 1, 0, $urandom, "b2b 1 no rw");
        run_access(0, 32'hA8, $urandom, 5'd3, 1, 0, 2, $urandom, "b2b 2");
        run_access(1, 32'hAC, $urandom, 5'd4, 1, 2, 1, $urandom, "b2b 3");
    endtask

    task automatic test_reset_mid(input bit in_wait, input string name);
        bit bad = 0;
        next_cycle();
        drive_idle();
        mem_read_in  = 1'b1;
        reg_write_in = 1'b1;
        addr_in      = 32'h200;
        rd_in        = 5'd5;
        next_cycle();
        mem_if.mem_req_ready = in_wait;
        mem_if.mem_rsp_valid = 1'b0;
        if (in_wait) begin
            next_cycle();
            mem_if.mem_req_ready = 1'b0;
            next_cycle();
        end
        #1;
        chk({name, " busy before reset"}, 32'(stall_out), 32'd1);
        rst = 1'b1;
        #1;
        chk({name, " stall_out drops"}, 32'(stall_out), 32'd0);
        chk({name, " mem_req_valid drops"}, 32'(mem_if.mem_req_valid), 32'd0);
        chk({name, " load_valid_out"}, 32'(load_valid_out), 32'd0);
        chk({name, " err_out"}, 32'(err_out), 32'd0);
        chk({name, " load_data_out cleared"}, load_data_out, 32'd0);
        chk({name, " rd_out cleared"}, 32'(rd_out), 32'd0);
        exp_last_data = '0;
        exp_last_rd   = '0;
        next_cycle();
        drive_idle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = 32'hBAD0BAD0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            mem_if.mem_rsp_valid = 1'b0;
            #1;
            if (load_valid_out || stall_out || err_out || mem_if.mem_req_valid) bad = 1;
        end
        chk({name, " late response ignored"}, 32'(bad), 32'd0);
        chk({name, " load_data_out unchanged"}, load_data_out, 32'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int sel = $urandom_range(0, 9);
            if (sel < 2) begin
                test_illegal(sel == 0, "rand illegal");
            end else begin
                logic [DW-1:0] a = $urandom;
                int r = $urandom_range(0, 3);
                int d = $urandom_range(0, 4);
                a[1:0] = 2'b00;
                if ($urandom_range(0, 5) == 0) r = $urandom_range(5, 9);
                if ($urandom_range(0, 5) == 0) d = $urandom_range(4, 9);
                run_access(1'($urandom), a, $urandom, 5'($urandom), 1'($urandom),
                           r, d, $urandom, "rand access");
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_illegal(0, "misaligned");
        test_illegal(1, "both flags");
        test_timeout();
        test_resp_at_timeout();
        test_back_to_back();
        test_reset_mid(0, "reset in REQ");
        test_reset_mid(1, "reset in WAIT");
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
